// File: rtl/inject_arbiter.sv
// inject_arbiter: round-robin sharing of the NoC injection port between task-packet injectors.
// An owner keeps the port until the end of its packet, found by parsing the text/data sizes in the header.
module inject_arbiter #(
  parameter int N_SRC     = 2,
  parameter int FLIT_SIZE = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [N_SRC-1:0]           req_tx_i,
  input  logic [N_SRC*FLIT_SIZE-1:0] req_data_i,
  output logic [N_SRC-1:0]           req_credit_o,
  output logic                       tx_o,
  input  logic                       credit_i,
  output logic [FLIT_SIZE-1:0]       data_o,
  output logic [N_SRC-1:0]           grant_o,
  output logic                       busy_o
);
  localparam int IW = $clog2(N_SRC);
  localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

  state_t          state_q;
  logic [IW-1:0]   g_q, rr_q, win, rr_d;
  logic            found, fwd, xfer;
  logic [1:0]      hdr_cnt_q;
  logic [32:0]     sum_q, sum_d;
  logic [30:0]     pay_cnt_q, words;

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % N_SRC);
  endfunction

  // Forwarding is a pure pass-through of the owner's stream while a packet is open.
  assign fwd          = state_q != IDLE;
  assign tx_o         = fwd & req_tx_i[g_q];
  assign data_o       = fwd ? req_data_i[g_q*FLIT_SIZE +: FLIT_SIZE] : '0;
  assign req_credit_o = (fwd & credit_i) ? ONE << g_q : '0;
  assign xfer         = tx_o & credit_i;
  assign sum_d        = sum_q + 33'(data_o);
  assign words        = sum_q[32:2];
  assign rr_d         = wrap(int'(g_q) + 1);

  always_comb begin
    win   = rr_q;
    found = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!found && req_tx_i[wrap(int'(rr_q) + i)]) begin
        win   = wrap(int'(rr_q) + i);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      g_q       <= '0;
      rr_q      <= '0;
      grant_o   <= '0;
      busy_o    <= 1'b0;
      hdr_cnt_q <= '0;
      sum_q     <= '0;
      pay_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (found) begin
          state_q   <= HDR;
          g_q       <= win;
          grant_o   <= ONE << win;
          busy_o    <= 1'b1;
          hdr_cnt_q <= '0;
        end
        HDR: if (xfer) begin
          hdr_cnt_q <= hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd0) sum_q <= 33'(data_o);
          if (hdr_cnt_q == 2'd1) sum_q <= sum_d;
          if (hdr_cnt_q == 2'd3) begin
            if (words == '0) begin
              state_q <= IDLE;
              grant_o <= '0;
              busy_o  <= 1'b0;
              rr_q    <= rr_d;
            end else begin
              state_q   <= PAYLOAD;
              pay_cnt_q <= words;
            end
          end
        end
        PAYLOAD: if (xfer) begin
          pay_cnt_q <= pay_cnt_q - 31'd1;
          if (pay_cnt_q == 31'd1) begin
            state_q <= IDLE;
            grant_o <= '0;
            busy_o  <= 1'b0;
            rr_q    <= rr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inject_arbiter.sv
// tb_inject_arbiter: randomized packet traffic against a packet-level round-robin reference model.
module tb_inject_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [1:0]  req_tx, req_credit, grant;
  logic [63:0] req_data;
  logic        tx, credit, busy;
  logic [31:0] data;

  always #5 clk = ~clk;

  inject_arbiter #(.N_SRC(2), .FLIT_SIZE(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_tx_i(req_tx), .req_data_i(req_data),
    .req_credit_o(req_credit), .tx_o(tx), .credit_i(credit), .data_o(data),
    .grant_o(grant), .busy_o(busy)
  );

  logic [31:0] src_q [2][$];
  logic [31:0] mdl_q [2][$];
  logic [31:0] exp_q [$];
  int checks = 0, failures = 0, xfers = 0;
  int tx_pct [2];
  int cr_pct;
  int m_own = -1, m_rem = 0, m_rr = 0;
  bit pop [2];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic add_pkt(input int k, input logic [31:0] t, input logic [31:0] d);
    logic [31:0] f [$];
    longint w;
    w = (longint'(t) + longint'(d)) >> 2;
    f = '{t, d, $urandom, $urandom};
    for (longint i = 0; i < w; i++) f.push_back($urandom);
    foreach (f[i]) begin
      src_q[k].push_back(f[i]);
      mdl_q[k].push_back(f[i]);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      req_tx[k] = src_q[k].size() > 0 && $urandom_range(99) < tx_pct[k];
      req_data[k*32 +: 32] = src_q[k].size() > 0 ? src_q[k][0] : 32'h0;
    end
    credit = $urandom_range(99) < cr_pct;
  endtask

  // Model: a granted packet is 4 + (text+data)/4 flits; the port is released after that many transfers.
  task automatic step();
    logic [1:0] eg;
    logic [31:0] t, d;
    longint n;
    @(negedge clk);
    eg = 2'b0;
    if (m_own >= 0) eg[m_own] = 1'b1;
    chk("grant", 64'(grant), 64'(eg));
    chk("busy", 64'(busy), 64'(m_own >= 0));
    chk("tx", 64'(tx), 64'(m_own >= 0 && req_tx[m_own]));
    chk("req_credit", 64'(req_credit), 64'(credit ? eg : 2'b0));
    if (m_own >= 0) chk("data_follow", 64'(data), 64'(req_data[m_own*32 +: 32]));
    for (int k = 0; k < 2; k++) pop[k] = req_tx[k] & req_credit[k];
    if (m_own < 0) begin
      for (int i = 0; i < 2 && m_own < 0; i++)
        if (req_tx[(m_rr + i) % 2]) m_own = (m_rr + i) % 2;
      if (m_own >= 0) begin
        if (mdl_q[m_own].size() < 4) begin
          failures++;
          $display("FAIL model_underflow actual=%0d required=4", mdl_q[m_own].size());
          m_own = -1;
        end else begin
          t = mdl_q[m_own][0];
          d = mdl_q[m_own][1];
          n = 4 + ((longint'(t) + longint'(d)) >> 2);
          m_rem = int'(n);
          for (longint i = 0; i < n && mdl_q[m_own].size() > 0; i++) exp_q.push_back(mdl_q[m_own].pop_front());
        end
      end
    end else if (req_tx[m_own] && credit) begin
      m_rem--;
      if (m_rem == 0) begin
        m_rr = (m_own + 1) % 2;
        m_own = -1;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) if (pop[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    drive();
  endtask

  task automatic drain(input string n);
    int c;
    drive();
    for (c = 0; c < 3000; c++) begin
      if (m_own < 0 && exp_q.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0) break;
      step();
    end
    chk({n, "_drained"}, 64'(c < 3000), 64'(1));
  endtask

  always @(negedge clk) begin
    if (rst_n && tx && credit) begin
      xfers++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL flit_unexpected actual=%h required=none", data);
      end else chk("flit", 64'(data), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    int x0, c;
    tx_pct = '{100, 100};
    cr_pct = 100;
    req_tx = '0;
    req_data = '0;
    credit = 1'b0;
    #12;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_tx", 64'(tx), 64'(0));
    chk("rst_data", 64'(data), 64'(0));
    chk("rst_credit", 64'(req_credit), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    add_pkt(0, 32'h20, 32'h10);
    drain("single");
    add_pkt(0, 8, 0);
    add_pkt(1, 4, 4);
    drain("pair1");
    add_pkt(0, 4, 4);
    add_pkt(1, 8, 0);
    drain("pair2");
    add_pkt(0, 0, 0);
    add_pkt(0, 6, 1);
    add_pkt(1, 3, 0);
    drain("edges");
    tx_pct = '{70, 80};
    cr_pct = 60;
    for (int i = 0; i < 12; i++) add_pkt($urandom_range(1), $urandom_range(40), $urandom_range(20));
    drain("random");
    tx_pct = '{100, 100};
    cr_pct = 100;
    add_pkt(0, 32, 0);
    drive();
    x0 = xfers;
    for (c = 0; c < 100 && xfers - x0 < 6; c++) step();
    chk("reach_payload", 64'(xfers - x0), 64'(6));
    rst_n = 1'b0;
    #1;
    chk("arst_grant", 64'(grant), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_tx", 64'(tx), 64'(0));
    chk("arst_data", 64'(data), 64'(0));
    chk("arst_credit", 64'(req_credit), 64'(0));
    for (int k = 0; k < 2; k++) begin
      src_q[k].delete();
      mdl_q[k].delete();
    end
    exp_q.delete();
    m_own = -1;
    m_rr = 0;
    m_rem = 0;
    req_tx = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    add_pkt(1, 4, 0);
    add_pkt(0, 4, 0);
    drain("after_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
